// File: rtl/phase_update_scheduler_pkg.sv
// Shared types for the ONN phase update scheduler: FSM encoding and phase word.
// Imported by the scheduler top and its phase register file.
package phase_update_scheduler_pkg;

    localparam int PW_DEF = 4;

    typedef logic [PW_DEF-1:0] phase_t;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_MEAS    = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

    // Host-side writes and run starts are only accepted while the scheduler is parked.
    function automatic logic is_parked(state_t s);
        return (s == ST_IDLE) || (s == ST_DONE);
    endfunction

    function automatic logic is_busy(state_t s);
        return (s == ST_LOAD) || (s == ST_MEAS) || (s == ST_CAPTURE);
    endfunction

endpackage

// File: rtl/phase_update_scheduler_phase_regfile.sv
// Per-neuron phase register file: N x PW, one write port, two combinational read ports.
// Synchronous clear on reset; a read of the address being written returns the old value.
module phase_regfile
    import phase_update_scheduler_pkg::*;
#(
    parameter int N    = 8,
    parameter int IDXW = 3,
    parameter int PW   = PW_DEF
) (
    input  logic            sclk_i,
    input  logic            re_i,
    input  logic            we_i,
    input  logic [IDXW-1:0] waddr_i,
    input  logic [PW-1:0]   wdata_i,
    input  logic [IDXW-1:0] raddr_a_i,
    output logic [PW-1:0]   rdata_a_o,
    input  logic [IDXW-1:0] raddr_b_i,
    output logic [PW-1:0]   rdata_b_o
);

    logic [PW-1:0] mem_q [N];

    always_ff @(posedge sclk_i) begin
        for (int i = 0; i < N; i++) begin
            if (re_i) begin
                mem_q[i] <= '0;
            end else if (we_i && (waddr_i == IDXW'(i))) begin
                mem_q[i] <= wdata_i;
            end
        end
    end

    // Decoded read muxes; addresses beyond N-1 read as zero.
    always_comb begin
        rdata_a_o = '0;
        rdata_b_o = '0;
        for (int i = 0; i < N; i++) begin
            if (raddr_a_i == IDXW'(i)) begin
                rdata_a_o = mem_q[i];
            end
            if (raddr_b_i == IDXW'(i)) begin
                rdata_b_o = mem_q[i];
            end
        end
    end

endmodule

// File: rtl/phase_update_scheduler.sv
// Time-multiplexes one phase measurement unit across N neurons: LOAD, WINDOW-cycle MEAS, CAPTURE.
// Sweeps repeat until STABLE_SWEEPS unchanged sweeps or MAX_SWEEPS; per-neuron latency WINDOW+2.
module phase_update_scheduler
    import phase_update_scheduler_pkg::*;
#(
    parameter int N             = 8,
    parameter int IDXW          = 3,
    parameter int PW            = PW_DEF,
    parameter int WINDOW        = 32,
    parameter int MAX_SWEEPS    = 16,
    parameter int STABLE_SWEEPS = 2,
    parameter int SCW           = 5
) (
    input  logic            sclk,
    input  logic            re,
    input  logic            start,
    input  logic            init_we,
    input  logic [IDXW-1:0] init_addr,
    input  logic [PW-1:0]   init_phase,
    input  logic [IDXW-1:0] rd_addr,
    output logic [PW-1:0]   rd_phase,
    output logic [IDXW-1:0] sel,
    output logic            meas_re,
    output logic [PW-1:0]   phi_out,
    input  logic [PW-1:0]   meas_phase,
    output logic            busy,
    output logic            done,
    output logic            converged,
    output logic [SCW-1:0]  sweep_cnt
);

    localparam int WCW = (WINDOW > 2) ? $clog2(WINDOW) : 1;
    localparam int STW = $clog2(STABLE_SWEEPS + 1);

    state_t          state_q,   state_d;
    logic [IDXW-1:0] idx_q,     idx_d;
    logic [WCW-1:0]  wcnt_q,    wcnt_d;
    logic [SCW-1:0]  sweep_q,   sweep_d;
    logic [STW-1:0]  stable_q,  stable_d;
    logic            changed_q, changed_d;
    logic            conv_q,    conv_d;

    logic            changed_any;
    logic [SCW-1:0]  sweep_nx;
    logic [STW-1:0]  stable_nx;

    logic            rf_we;
    logic [IDXW-1:0] rf_waddr;
    logic [PW-1:0]   rf_wdata;
    logic [PW-1:0]   cur_phase;

    // Capture and host init are mutually exclusive by state, so a simple priority mux suffices.
    always_comb begin
        rf_we    = 1'b0;
        rf_waddr = init_addr;
        rf_wdata = init_phase;
        if (state_q == ST_CAPTURE) begin
            rf_we    = 1'b1;
            rf_waddr = idx_q;
            rf_wdata = meas_phase;
        end else if (is_parked(state_q) && init_we) begin
            rf_we    = 1'b1;
        end
    end

    phase_regfile #(
        .N    (N),
        .IDXW (IDXW),
        .PW   (PW)
    ) u_regfile (
        .sclk_i    (sclk),
        .re_i      (re),
        .we_i      (rf_we),
        .waddr_i   (rf_waddr),
        .wdata_i   (rf_wdata),
        .raddr_a_i (idx_q),
        .rdata_a_o (cur_phase),
        .raddr_b_i (rd_addr),
        .rdata_b_o (rd_phase)
    );

    always_ff @(posedge sclk) begin
        if (re) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            wcnt_q    <= '0;
            sweep_q   <= '0;
            stable_q  <= '0;
            changed_q <= 1'b0;
            conv_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            wcnt_q    <= wcnt_d;
            sweep_q   <= sweep_d;
            stable_q  <= stable_d;
            changed_q <= changed_d;
            conv_q    <= conv_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        wcnt_d      = wcnt_q;
        sweep_d     = sweep_q;
        stable_d    = stable_q;
        changed_d   = changed_q;
        conv_d      = conv_q;
        changed_any = changed_q | (meas_phase != cur_phase);
        sweep_nx    = sweep_q + 1'b1;
        stable_nx   = '0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d   = ST_LOAD;
                    idx_d     = '0;
                    sweep_d   = '0;
                    stable_d  = '0;
                    changed_d = 1'b0;
                    conv_d    = 1'b0;
                end
            end
            ST_LOAD: begin
                wcnt_d  = '0;
                state_d = ST_MEAS;
            end
            ST_MEAS: begin
                wcnt_d = wcnt_q + 1'b1;
                if (wcnt_q == WCW'(WINDOW - 1)) begin
                    state_d = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                if (idx_q != IDXW'(N - 1)) begin
                    idx_d     = idx_q + 1'b1;
                    changed_d = changed_any;
                    state_d   = ST_LOAD;
                end else begin
                    // End of sweep: convergence wins over the sweep limit when both hit.
                    if (changed_any) begin
                        stable_nx = '0;
                    end else if (stable_q == STW'(STABLE_SWEEPS)) begin
                        stable_nx = stable_q;
                    end else begin
                        stable_nx = stable_q + 1'b1;
                    end
                    sweep_d   = sweep_nx;
                    stable_d  = stable_nx;
                    changed_d = 1'b0;
                    idx_d     = '0;
                    if (stable_nx == STW'(STABLE_SWEEPS)) begin
                        state_d = ST_DONE;
                        conv_d  = 1'b1;
                    end else if (sweep_nx == SCW'(MAX_SWEEPS)) begin
                        state_d = ST_DONE;
                        conv_d  = 1'b0;
                    end else begin
                        state_d = ST_LOAD;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign sel       = idx_q;
    assign phi_out   = cur_phase;
    assign meas_re   = (state_q == ST_LOAD);
    assign busy      = is_busy(state_q);
    assign done      = (state_q == ST_DONE);
    assign converged = conv_q;
    assign sweep_cnt = sweep_q;

endmodule

// File: doc/phase_update_scheduler.md
Name: phase_update_scheduler

Overview:
- Time-multiplexes one phase-difference measurement unit across N oscillator neurons of the ONN.
- Holds the per-neuron phase register file and sequences each neuron in turn: load current phase into the unit, run a measurement window, write back the result.
- Sweeps repeat until the network settles (no phase change) or a sweep limit is reached.
- Sits between the host/init logic and the measurement unit plus the oscillator input muxes.

Parameters:
- N, 8, number of neurons sequenced
- IDXW, 3, neuron index width, ceil(log2(N)), minimum 1
- PW, 4, phase word width
- WINDOW, 32, sclk cycles per measurement window, minimum 2
- MAX_SWEEPS, 16, sweep limit before forced stop
- STABLE_SWEEPS, 2, consecutive no-change sweeps that declare convergence
- SCW, 5, sweep counter width, must hold MAX_SWEEPS

Ports:
- sclk  in  1  system clock, all logic on rising edge
- re  in  1  synchronous active-high reset
- start  in  1  one-cycle pulse that begins a run; sampled only in IDLE or DONE
- init_we  in  1  phase memory write strobe; honoured only in IDLE or DONE
- init_addr  in  IDXW  init write address
- init_phase  in  PW  init write data
- rd_addr  in  IDXW  host read address
- rd_phase  out  PW  combinational read of phase memory at rd_addr
- sel  out  IDXW  index of the neuron under measurement, drives the nin/nout muxes
- meas_re  out  1  load/reset strobe to the measurement unit
- phi_out  out  PW  stored phase of neuron sel, to the measurement unit
- meas_phase  in  PW  result from the measurement unit
- busy  out  1  high from the LOAD state through the final CAPTURE
- done  out  1  high in DONE
- converged  out  1  valid in DONE: 1 = stable exit, 0 = sweep-limit exit
- sweep_cnt  out  SCW  completed sweeps in the current run

Behaviour:
- Reset (re=1, has priority over everything):
  - State goes to IDLE; idx, window counter, sweep_cnt, the stable counter and the changed flag all clear to 0.
  - All phase memory entries clear to 0.
  - Outputs: sel=0, meas_re=0, busy=0, done=0, converged=0, sweep_cnt=0.
- Reset mid-run aborts immediately. No write-back occurs in that cycle.
- FSM states: IDLE, LOAD, MEAS, CAPTURE, DONE.
- IDLE/DONE + start=1:
  - Next state is LOAD.
  - Clear idx, sweep_cnt, the stable counter and the changed flag.
  - done and converged drop.
  - If init_we is also high in the same cycle, the write is performed before the run begins.
- LOAD (1 cycle):
  - meas_re=1, sel=idx, phi_out=mem[idx].
  - Next state is MEAS with the window counter at 0.
- MEAS (WINDOW cycles):
  - meas_re=0; sel and phi_out are held.
  - The counter increments each cycle. The last MEAS cycle is the one with counter=WINDOW-1; after it the state goes to CAPTURE.
- CAPTURE (1 cycle):
  - mem[idx] <= meas_phase.
  - changed |= (meas_phase != mem[idx]).
  - If idx<N-1: idx++, next state LOAD.
  - If idx=N-1 (end of sweep):
    - sweep_cnt++.
    - Stable counter: 0 if changed, otherwise +1 (saturating). changed clears.
    - idx wraps to 0.
    - Go to DONE with converged=1 if the updated stable counter = STABLE_SWEEPS.
    - Otherwise go to DONE with converged=0 if the updated sweep_cnt = MAX_SWEEPS.
    - Otherwise go to LOAD.
- Timing:
  - Per-neuron latency is WINDOW+2 cycles; a sweep is N*(WINDOW+2) cycles.
  - busy rises the cycle after start is sampled.
  - done rises the cycle after the final CAPTURE.
- DONE holds its outputs until start or re.
- Phase values are stored raw; modulo-2^PW wrap is the measurement unit's responsibility. The scheduler compares with plain equality.
- Ignored inputs:
  - start while busy.
  - init_we while busy (memory is unchanged).
- rd_phase is live at all times. A read at the address written in the same cycle returns the old value.
- Convergence takes precedence when the stable and limit conditions coincide in the same CAPTURE.

Decomposition:
- Shared package holds:
  - FSM state encoding (IDLE=0, LOAD=1, MEAS=2, CAPTURE=3, DONE=4, 3-bit).
  - PW default and the phase word type.
- One sub-module, phase_regfile:
  - N x PW entries, synchronous clear on re.
  - One write port, muxed between init and capture.
  - Two combinational read ports, for phi_out and rd_phase.

Test Plan:
- Reset then read-back: assert re 2 cycles; read all addresses → rd_phase=0; busy=0, done=0, sweep_cnt=0.
- Stable network (N=8, WINDOW=32):
  - Stimulus: init mem[i]=i; model returns meas_phase=phi_out; pulse start.
  - Required: done 2*8*34=544 cycles after busy rises; converged=1; sweep_cnt=2; mem unchanged.
- Per-neuron sequencing: check meas_re is high exactly 1 cycle per neuron; sel steps 0..7 every 34 cycles; phi_out equals mem[sel].
- Sweep limit:
  - Stimulus: model returns phi_out+1 (mod 16).
  - Required: DONE after 16 sweeps, converged=0, sweep_cnt=16, mem[i]=(i+16) mod 16=i.
- Settle after one sweep: model returns 5 on the first sweep, then echoes phi_out → converged=1, sweep_cnt=3, all mem=5.
- Mid-run events:
  - Stimulus: pulse start and init_we (addr 2, data 9) while busy in MEAS.
  - Required: both are ignored.
  - Then assert re in a CAPTURE cycle → IDLE next cycle, all mem=0, no write-back of meas_phase.
